// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths and the
// binary/Gray pointer conversions used by both clock domains.
package async_fifo_pkg;

    localparam int DEF_PTRWIDTH = 4;
    localparam int DEF_DWIDTH   = 8;
    localparam int DEF_CNTWIDTH = 16;

    // Conversions work on a 32-bit container; callers size-cast to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_wr_frontend_if.sv
// Bundle of the write front end's source handshake, controller handshake and
// memory write port. The front end sits on the slave side; the surrounding
// source/controller/memory logic sits on the master side.
interface async_fifo_wr_frontend_if
    import async_fifo_pkg::*;
#(
    parameter int PTRWIDTH = DEF_PTRWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int CNTWIDTH = DEF_CNTWIDTH
);

    logic                src_valid;
    logic [DWIDTH-1:0]   src_data;
    logic                src_ready;
    logic                push;
    logic                full;
    logic [PTRWIDTH:0]   wrptr_bin;
    logic                mem_we;
    logic [PTRWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0]   mem_wdata;
    logic [PTRWIDTH:0]   wrptr_gray;
    logic [CNTWIDTH-1:0] wr_count;
    logic                stall;

    modport slave (
        input  src_valid, src_data, full, wrptr_bin,
        output src_ready, push, mem_we, mem_waddr, mem_wdata, wrptr_gray, wr_count, stall
    );

    modport master (
        output src_valid, src_data, full, wrptr_bin,
        input  src_ready, push, mem_we, mem_waddr, mem_wdata, wrptr_gray, wr_count, stall
    );

endinterface

// File: rtl/async_fifo_skid_buf.sv
// Two-entry in-order valid/ready buffer. in_ready comes straight from a flop
// so the upstream source never sees a combinational path through this block.
// There is no bypass: a word accepted on an edge is visible at the head from
// the following cycle at the earliest.
module async_fifo_skid_buf #(
    parameter int DWIDTH = 8
) (
    input  logic              wclk,
    input  logic              reset_L,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready
);

    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic [DWIDTH-1:0] head_q;
    logic [DWIDTH-1:0] tail_q;
    logic [DWIDTH-1:0] head_d;
    logic [DWIDTH-1:0] tail_d;
    logic              accept;
    logic              drain;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head_q;

    // Next occupancy and entry contents; the head always holds the oldest word.
    always_comb begin
        occ_next = occ;
        head_d   = head_q;
        tail_d   = tail_q;
        case ({accept, drain})
            2'b10: begin
                if (occ == 2'd0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
                occ_next = occ + 2'd1;
            end
            2'b01: begin
                head_d   = tail_q;
                occ_next = occ - 2'd1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer state plus the registered ready, which looks one cycle ahead at occupancy.
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            occ      <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            occ      <= occ_next;
            head_q   <= head_d;
            tail_q   <= tail_d;
            in_ready <= (occ_next != 2'd2);
        end
    end

endmodule

// File: rtl/async_fifo_wr_frontend.sv
// Write-domain front end of the asynchronous FIFO: buffers source words,
// requests pushes from the write-pointer controller, drives the memory write
// port and publishes the registered Gray write pointer for the read domain.
module async_fifo_wr_frontend
    import async_fifo_pkg::*;
#(
    parameter int PTRWIDTH = DEF_PTRWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int CNTWIDTH = DEF_CNTWIDTH
) (
    input logic                     wclk,
    input logic                     reset_L,
    async_fifo_wr_frontend_if.slave bus
);

    localparam int PW = PTRWIDTH + 1;

    logic                push_w;
    logic                ready_w;
    logic                drain_ok;
    logic                mem_we_w;
    logic [DWIDTH-1:0]   head_w;
    logic [PW-1:0]       gray_d;
    logic [PW-1:0]       gray_q;
    logic [CNTWIDTH-1:0] wr_count_q;
    logic                stall_q;

    assign drain_ok = !bus.full;

    async_fifo_skid_buf #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .wclk     (wclk),
        .reset_L  (reset_L),
        .in_valid (bus.src_valid),
        .in_data  (bus.src_data),
        .in_ready (ready_w),
        .out_valid(push_w),
        .out_data (head_w),
        .out_ready(drain_ok)
    );

    assign mem_we_w = push_w && !bus.full;
    assign gray_d   = PW'(bin2gray(32'(bus.wrptr_bin)));

    assign bus.src_ready  = ready_w;
    assign bus.push       = push_w;
    assign bus.mem_we     = mem_we_w;
    assign bus.mem_waddr  = bus.wrptr_bin[PTRWIDTH-1:0];
    assign bus.mem_wdata  = head_w;
    assign bus.wrptr_gray = gray_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.stall      = stall_q;

    // Gray pointer is re-registered every edge so the read domain samples a flop output.
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    // Written-word counter sticks at all-ones instead of wrapping.
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            wr_count_q <= '0;
        end else if (mem_we_w && (wr_count_q != '1)) begin
            wr_count_q <= wr_count_q + CNTWIDTH'(1);
        end
    end

    // Stall flags a cycle in which a push was blocked by the controller's full flag.
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= push_w && bus.full;
        end
    end

endmodule
